// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the bulbul ALU control sequencer: instruction classes,
// ALU control codes, M-extension func3 values, FSM states and the base-ISA
// field decoder used by the top level.
package alu_ctrl_pkg;

  localparam logic [2:0] AOP_R   = 3'b000;
  localparam logic [2:0] AOP_I   = 3'b001;
  localparam logic [2:0] AOP_BR  = 3'b010;
  localparam logic [2:0] AOP_JAL = 3'b011;
  localparam logic [2:0] AOP_LD  = 3'b100;
  localparam logic [2:0] AOP_ST  = 3'b101;
  localparam logic [2:0] AOP_LUI = 3'b110;
  localparam logic [2:0] AOP_BAD = 3'b111;

  localparam logic [4:0] ALUC_ADD  = 5'b00000;
  localparam logic [4:0] ALUC_SUB  = 5'b01000;
  localparam logic [4:0] ALUC_SRA  = 5'b01101;
  localparam logic [4:0] ALUC_BEQ  = 5'b10000;
  localparam logic [4:0] ALUC_BNE  = 5'b10001;
  localparam logic [4:0] ALUC_BLT  = 5'b10100;
  localparam logic [4:0] ALUC_BGE  = 5'b10101;
  localparam logic [4:0] ALUC_BLTU = 5'b10110;
  localparam logic [4:0] ALUC_BGEU = 5'b10111;
  localparam logic [4:0] ALUC_JAL  = 5'b11111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       illegal;
    logic [4:0] aluc;
    logic       is_m;
  } dec_t;

  // Base-ISA decode; illegal combinations always leave aluc at ALUC_ADD (zero).
  function automatic dec_t decode(input logic [2:0] aop, input logic [2:0] f3,
                                  input logic [1:0] f7);
    dec_t d;
    d.illegal = 1'b0;
    d.aluc    = ALUC_ADD;
    d.is_m    = 1'b0;
    case (aop)
      AOP_R, AOP_I: begin
        if (f7[0]) begin
          if (aop == AOP_R) d.is_m = 1'b1;
          else d.illegal = 1'b1;
        end else if (f7[1] && (f3 != 3'b000) && (f3 != 3'b101)) begin
          d.illegal = 1'b1;
        end else if ((aop == AOP_I) && (f3 == 3'b000)) begin
          d.aluc = ALUC_ADD;
        end else begin
          d.aluc = {1'b0, f7[1], f3};
        end
      end
      AOP_BR: begin
        if ((f3 == 3'b010) || (f3 == 3'b011)) d.illegal = 1'b1;
        else d.aluc = {2'b10, f3};
      end
      AOP_JAL: d.aluc = ALUC_JAL;
      AOP_BAD: d.illegal = 1'b1;
      default: d.aluc = ALUC_ADD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_muldiv.sv
// muldiv_iter: iterative RV M-extension datapath. Converts operands to
// magnitudes, runs one shift-add (multiply) or restoring (divide) step per
// step_i, detects the divide fast-path cases and applies the sign fix-up.
// res_o is the result as it will be after the current step (or the fast-path
// result while start_i is high), so the parent can latch it on the edge that
// enters DONE.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            fast_o,
  output logic [XLEN-1:0] res_o
);

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   is_div, sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]        mag_a, mag_b, fast_res;
  logic                   div_zero, div_ovf;

  logic [2:0]      op_q;
  logic            neg_q, neg_r_q;
  logic [XLEN-1:0] dvs_q, hi_q, lo_q;

  logic [XLEN:0]     sum, rem_sh, diff;
  logic              ge;
  logic [XLEN-1:0]   hi_s, lo_s, quo, rem;
  logic [2*XLEN-1:0] prod, prod_f, fin_res;

  assign rs1_s = rs1_i;
  assign rs2_s = rs2_i;

  // Operand signedness, magnitudes and divide special-case detection
  always_comb begin
    is_div   = func3_i[2];
    sgn_a    = is_div ? !func3_i[0] : (func3_i != F3_MULHU);
    sgn_b    = is_div ? !func3_i[0] : ((func3_i == F3_MUL) || (func3_i == F3_MULH));
    neg_a    = sgn_a && (rs1_s < 0);
    neg_b    = sgn_b && (rs2_s < 0);
    mag_a    = neg_a ? -rs1_i : rs1_i;
    mag_b    = neg_b ? -rs2_i : rs2_i;
    div_zero = is_div && (rs2_i == '0);
    div_ovf  = is_div && !func3_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_i);
    fast_o   = div_zero || div_ovf;
    if (div_zero) fast_res = func3_i[1] ? rs1_i : '1;
    else          fast_res = func3_i[1] ? '0 : rs1_i;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    sum    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? dvs_q : '0)};
    rem_sh = {hi_q, lo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = !diff[XLEN];
    if (op_q[2]) begin
      hi_s = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      lo_s = {lo_q[XLEN-2:0], ge};
    end else begin
      {hi_s, lo_s} = {sum, lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection
  always_comb begin
    prod   = {hi_s, lo_s};
    prod_f = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_s : lo_s;
    rem    = neg_r_q ? -hi_s : hi_s;
    case (op_q)
      F3_MUL:                       fin_res = {{XLEN{1'b0}}, prod_f[XLEN-1:0]};
      F3_MULH, F3_MULHSU, F3_MULHU: fin_res = {{XLEN{1'b0}}, prod_f[2*XLEN-1:XLEN]};
      F3_DIV, F3_DIVU:              fin_res = {{XLEN{1'b0}}, quo};
      default:                      fin_res = {{XLEN{1'b0}}, rem};
    endcase
    res_o = (start_i && fast_o) ? fast_res : fin_res[XLEN-1:0];
  end

  // Datapath registers: load magnitudes on start, iterate while stepping
  always_ff @(posedge clk_i) begin
    if (start_i) begin
      op_q    <= func3_i;
      neg_q   <= neg_a ^ neg_b;
      neg_r_q <= neg_a;
      hi_q    <= '0;
      dvs_q   <= is_div ? mag_b : mag_a;
      lo_q    <= is_div ? mag_a : mag_b;
    end else if (step_i) begin
      hi_q <= hi_s;
      lo_q <= lo_s;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with an optional iterative
// M-extension unit. Build macro BULBUL_MULDIV_EN enables multiply/divide;
// without it R-type ops with func7[0]=1 are flagged illegal and the block
// never stalls.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [2:0]      aluop_i,
  input  logic [2:0]      func3_i,
  input  logic [1:0]      func7_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            aluc_valid_o,
  output logic [4:0]      aluc_o,
  output logic            illegal_o,
  output logic            md_valid_o,
  output logic [XLEN-1:0] md_result_o
);

  dec_t dec;
  logic accept, issue_aluc, issue_illegal;

  assign dec = decode(aluop_i, func3_i, func7_i);

`ifdef BULBUL_MULDIV_EN
  localparam int CNT_W = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic            take_m, fast, finish;
  logic [XLEN-1:0] md_res;

  assign ready_o       = (state_q != ST_CALC);
  assign accept        = valid_i && ready_o && !flush_i;
  assign take_m        = accept && dec.is_m;
  assign issue_aluc    = accept && !dec.is_m;
  assign issue_illegal = dec.illegal;
  assign finish        = (state_q == ST_CALC) && !flush_i && (cnt_q == '0);
  assign md_valid_o    = (state_q == ST_DONE);

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk_i   (clk_i),
    .start_i (take_m),
    .step_i  (state_q == ST_CALC),
    .func3_i (func3_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .fast_o  (fast),
    .res_o   (md_res)
  );

  // Next state: flush wins; IDLE and DONE both accept new work
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CALC: begin
        if (flush_i)            state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_DONE;
      end
      default: begin
        if (take_m) state_d = fast ? ST_DONE : ST_CALC;
        else        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, iteration counter and held M-extension result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      md_result_o <= '0;
    end else begin
      state_q <= state_d;
      if (take_m && !fast)                        cnt_q <= CNT_W'(XLEN-1);
      else if ((state_q == ST_CALC) && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
      if (finish || (take_m && fast)) md_result_o <= md_res;
    end
  end
`else
  logic unused_md;

  assign ready_o       = 1'b1;
  assign accept        = valid_i && !flush_i;
  assign issue_aluc    = accept;
  assign issue_illegal = dec.illegal || dec.is_m;
  assign md_valid_o    = 1'b0;
  assign md_result_o   = '0;
  assign unused_md     = ^{rs1_i, rs2_i};
`endif

  // Registered decode result, one-cycle pulse per accepted non-M op
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aluc_valid_o <= 1'b0;
      illegal_o    <= 1'b0;
      aluc_o       <= ALUC_ADD;
    end else begin
      aluc_valid_o <= issue_aluc;
      illegal_o    <= issue_aluc && issue_illegal;
      if (issue_aluc) aluc_o <= issue_illegal ? ALUC_ADD : dec.aluc;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed cases plus randomized traffic,
// all compared every cycle against a transaction-level reference model.
module tb_alu_ctrl_seq;
  localparam int XLEN = 32;
`ifdef BULBUL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk, rst, valid, flush, ready;
  logic [2:0]  aluop, func3;
  logic [1:0]  func7;
  logic [31:0] rs1, rs2, md_result;
  logic        aluc_valid, illegal, md_valid;
  logic [4:0]  aluc;

  alu_ctrl_seq #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .flush_i(flush),
    .aluop_i(aluop), .func3_i(func3), .func7_i(func7), .rs1_i(rs1), .rs2_i(rs2),
    .aluc_valid_o(aluc_valid), .aluc_o(aluc), .illegal_o(illegal),
    .md_valid_o(md_valid), .md_result_o(md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_busy = 0;
  bit          m_done = 0, m_avld = 0, m_ill = 0, chk_en = 0;
  logic [31:0] m_res = '0, m_pend = '0;
  logic [4:0]  m_aluc = '0;

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic ref_dec(input logic [2:0] op, input logic [2:0] f3, input logic [1:0] f7,
                         output bit ill, output logic [4:0] code, output bit m);
    ill = 0; code = 5'b00000; m = 0;
    if (op == 3'd7) ill = 1;
    else if (op == 3'd3) code = 5'b11111;
    else if (op >= 3'd4) code = 5'b00000;
    else if (op == 3'd2) begin
      if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
      else code = 5'b10000 | {2'b00, f3};
    end else if (f7[0]) begin
      if (op == 3'd0 && MD_EN) m = 1;
      else ill = 1;
    end else if (f7[1]) begin
      if (f3 == 3'd0) code = (op == 3'd0) ? 5'b01000 : 5'b00000;
      else if (f3 == 3'd5) code = 5'b01101;
      else ill = 1;
    end else code = {2'b00, f3};
  endtask

  task automatic model_step(input bit r, input bit v, input bit fl, input logic [2:0] op,
                            input logic [2:0] f3, input logic [1:0] f7,
                            input logic [31:0] a, input logic [31:0] b);
    bit ill, m;
    logic [4:0] code;
    logic [31:0] res;
    if (r) begin
      m_busy = 0; m_done = 0; m_avld = 0; m_ill = 0; m_aluc = '0; m_res = '0;
    end else begin
      m_avld = 0; m_ill = 0; m_done = 0;
      if (m_busy > 0) begin
        if (fl) m_busy = 0;
        else begin
          m_busy--;
          if (m_busy == 0) begin m_done = 1; m_res = m_pend; end
        end
      end else if (v && !fl) begin
        ref_dec(op, f3, f7, ill, code, m);
        if (m) begin
          res = ref_md(f3, a, b);
          if (ref_fast(f3, a, b)) begin m_done = 1; m_res = res; end
          else begin m_busy = XLEN; m_pend = res; end
        end else begin
          m_avld = 1; m_ill = ill; m_aluc = ill ? 5'b00000 : code;
        end
      end
    end
  endtask

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("ready", ready, (MD_EN && m_busy > 0) ? 0 : 1);
      check("aluc_valid", aluc_valid, m_avld);
      check("illegal", illegal, m_ill);
      check("md_valid", md_valid, m_done);
      check("md_result", md_result, m_res);
      if (m_avld) check("aluc", aluc, m_aluc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit r, input bit v, input bit fl, input logic [2:0] op,
                       input logic [2:0] f3, input logic [1:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = r; valid = v; flush = fl; aluop = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b;
    model_step(r, v, fl, op, f3, f7, a, b);
    chk_en = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom);
  endtask

  // Issue an M op, then idle until md_valid (left in DONE) or budget runs out
  task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int rdy_low);
    lat = 0; rdy_low = 0; res = 'x;
    drive(0, 1, 0, 3'd0, f3, 2'b01, a, b);
    for (int k = 0; k < 40; k++) begin
      if (md_valid === 1'b1) begin lat = k + 1; res = md_result; break; end
      if (ready === 1'b0) rdy_low++;
      idle();
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      4: return -32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int lat, rl;
    rst = 1; valid = 0; flush = 0; aluop = 0; func3 = 0; func7 = 0; rs1 = 0; rs2 = 0;

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    check("rst_ready", ready, 1);
    check("rst_aluc_valid", aluc_valid, 0);
    check("rst_md_valid", md_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_aluc", aluc, 5'b00000);
    check("rst_md_result", md_result, 0);

    // Pin the reference model with hand-computed values
    check("pin_mul", ref_md(3'd0, 32'hFFFF_FFFD, 32'd7), 32'hFFFF_FFEB);
    check("pin_mulhu", ref_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_div", ref_md(3'd4, -32'd100, 32'd7), 32'hFFFF_FFF2);
    check("pin_rem", ref_md(3'd6, -32'd100, 32'd7), 32'hFFFF_FFFE);
    check("pin_div0", ref_md(3'd4, 32'd100, 32'd0), 32'hFFFF_FFFF);
    check("pin_removf", ref_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

    // SUB, then an illegal branch
    drive(0, 1, 0, 3'b000, 3'b000, 2'b10, 0, 0);
    check("sub_valid", aluc_valid, 1);
    check("sub_aluc", aluc, 5'b01000);
    check("sub_ready", ready, 1);
    drive(0, 1, 0, 3'b010, 3'b010, 2'b00, 0, 0);
    check("br_illegal", illegal, 1);
    check("br_aluc", aluc, 5'b00000);
    drive(0, 1, 0, 3'b001, 3'b101, 2'b10, 0, 0);
    check("srai_aluc", aluc, 5'b01101);

`ifdef BULBUL_MULDIV_EN
    run_m(3'd0, 32'hFFFF_FFFD, 32'd7, res, lat, rl);
    check("mul_res", res, 32'hFFFF_FFEB);
    check("mul_lat", lat, 33);
    check("mul_rdy_low", rl, 32);
    run_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, rl);
    check("mulhu_res", res, 32'hFFFF_FFFE);
    run_m(3'd5, 32'd100, 32'd7, res, lat, rl);
    check("divu_res", res, 32'd14);
    run_m(3'd7, 32'd100, 32'd7, res, lat, rl);
    check("remu_res", res, 32'd2);
    run_m(3'd4, -32'd100, 32'd7, res, lat, rl);
    check("div_res", res, 32'hFFFF_FFF2);
    run_m(3'd6, -32'd100, 32'd7, res, lat, rl);
    check("rem_res", res, 32'hFFFF_FFFE);
    run_m(3'd4, 32'd100, 32'd0, res, lat, rl);
    check("div0_res", res, 32'hFFFF_FFFF);
    check("div0_lat", lat, 1);
    check("div0_rdy_low", rl, 0);
    run_m(3'd6, 32'd100, 32'd0, res, lat, rl);
    check("rem0_res", res, 32'd100);
    check("rem0_lat", lat, 1);
    run_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rl);
    check("divovf_res", res, 32'h8000_0000);
    check("divovf_lat", lat, 1);
    run_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rl);
    check("removf_res", res, 32'h0);

    // Flush at CALC cycle 10, then an immediate ADD
    drive(0, 1, 0, 3'd0, 3'd0, 2'b01, 32'd123, 32'd456);
    for (int i = 0; i < 9; i++) idle();
    drive(0, 0, 1, 3'd0, 3'd0, 2'b00, 0, 0);
    check("flush_ready", ready, 1);
    check("flush_md_valid", md_valid, 0);
    drive(0, 1, 0, 3'd0, 3'd0, 2'b00, 0, 0);
    check("flush_add_valid", aluc_valid, 1);
    for (int i = 0; i < 36; i++) idle();

    // Reset mid-CALC, then an immediate ADD
    drive(0, 1, 0, 3'd0, 3'd4, 2'b01, 32'd999, 32'd3);
    for (int i = 0; i < 5; i++) idle();
    drive(1, 0, 0, 3'd0, 3'd0, 2'b00, 0, 0);
    check("rstmid_ready", ready, 1);
    check("rstmid_md_valid", md_valid, 0);
    drive(0, 1, 0, 3'd0, 3'd0, 2'b00, 0, 0);
    check("rstmid_add_valid", aluc_valid, 1);
    for (int i = 0; i < 36; i++) idle();

    // ADD accepted while in DONE
    run_m(3'd5, 32'd100, 32'd7, res, lat, rl);
    check("b2b_in_done", md_valid, 1);
    drive(0, 1, 0, 3'd0, 3'd0, 2'b00, 0, 0);
    check("b2b_add_valid", aluc_valid, 1);
    check("b2b_add_aluc", aluc, 5'b00000);
    check("b2b_md_valid", md_valid, 0);
`else
    drive(0, 1, 0, 3'd0, 3'd0, 2'b01, 32'd5, 32'd7);
    check("mnone_illegal", illegal, 1);
    check("mnone_ready", ready, 1);
    check("mnone_md_valid", md_valid, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 200) == 0, ($urandom % 4) != 0, ($urandom % 30) == 0,
            3'($urandom), 3'($urandom), 2'($urandom), rnd_val(), rnd_val());
    end
    for (int i = 0; i < 40; i++) idle();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised successor to the single-cycle ALU control decoder for the bulbul RV32 core. It sits between decode and execute. It registers the decoded ALU control code for base-ISA operations with one-cycle latency. It runs RV M-extension multiply/divide operations iteratively, one bit per cycle, with a valid/ready handshake that stalls the pipeline. Undefined field combinations are flagged as illegal and never produce X.

## Interface
- XLEN, 32: operand/result width (≥8, even)
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  operation presented
- ready_o  out  1  block can accept this cycle
- flush_i  in  1  abort the in-flight operation
- aluop_i  in  3  instruction class: 000 R, 001 I, 010 branch, 011 JAL/JALR, 100/101/110 load/store/LUI
- func3_i  in  3  instr[14:12]
- func7_i  in  2  bit1 = instr[30], bit0 = instr[25]
- rs1_i, rs2_i  in  XLEN  operands
- aluc_valid_o  out  1  aluc_o/illegal_o valid (one-cycle pulse)
- aluc_o  out  5  ALU control code
- illegal_o  out  1  undefined combination
- md_valid_o  out  1  M-extension result valid (one-cycle pulse)
- md_result_o  out  XLEN  M-extension result

## Operation
- Accept on `valid_i && ready_o`; fields and operands are latched.
- R/I, func7_i[0]=0: aluc_o = {1'b0, func7_i[1], func3_i}.
  - func7_i[1]=1 is legal only for func3 000 (R only; SUB = 01000) and func3 101 (SRA = 01101).
  - I-type func3 000 ignores func7_i[1].
- Branch: aluc_o = {2'b10, func3_i}; func3 010/011 are illegal.
- JAL/JALR: 11111. Load/store/LUI: 00000. aluop 111: illegal.
- Illegal: illegal_o=1 and aluc_o=00000, both with aluc_valid_o.
- R-type with func7_i[0]=1 is an M operation. func3 selects: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. No aluc_valid_o is issued.
- Multiply:
  - Convert operands to magnitudes per signedness (MULHSU: rs1 signed, rs2 unsigned).
  - Shift-add over XLEN cycles into a 2·XLEN product.
  - Negate if the signs differ.
  - MUL returns the low half; MULH* return the high half.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - Signed quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- Special cases take the fast path (no CALC):
  - Divide by zero: quotient all-ones, remainder = rs1.
  - Signed overflow, rs1 = 1 followed by XLEN-1 zeros and rs2 = all-ones: quotient = rs1, remainder 0.
- FSM:
  - IDLE: ready_o=1. A non-M op stays in IDLE. A normal M op goes to CALC. A fast-path M op goes to DONE.
  - CALC: ready_o=0. The iteration counter loads XLEN-1 and decrements each cycle; at 0 go to DONE.
  - DONE: md_valid_o=1 and ready_o=1. Accepting a new op here follows the IDLE rules; otherwise return to IDLE.
- flush_i has priority over valid_i:
  - In CALC or DONE it forces IDLE next cycle and suppresses md_valid_o.
  - A flush in the same cycle as an accept cancels the accept.
- Reset values: IDLE; ready_o=1; aluc_valid_o, md_valid_o, illegal_o = 0; aluc_o = 00000; md_result_o = 0; counter = 0.
- Reset mid-CALC discards the operation.

## Timing
- Non-M: aluc_valid_o is asserted the cycle after acceptance. Back-to-back accepts sustain 1 op/cycle.
- M normal: accept at edge T. CALC occupies cycles T+1..T+XLEN. md_valid_o is high in cycle T+XLEN+1. ready_o is low from T+1 through T+XLEN.
- M fast path: md_valid_o is high in cycle T+1, and ready_o stays high.
- md_result_o holds its value until the next M completion.
- Outputs are registered only; there are no combinational input-to-output paths except ready_o, which is decoded from state.

## Configuration
- BULBUL_MULDIV_EN defined: M-extension support as described above.
- BULBUL_MULDIV_EN undefined:
  - No multiply/divide logic is instantiated.
  - func7_i[0]=1 with R-type is illegal (illegal_o pulse one cycle after accept).
  - ready_o is tied to 1; md_valid_o and md_result_o are tied to 0.

## Structure
- Package alu_ctrl_pkg holds:
  - aluop class localparams;
  - aluc code localparams (ALUC_ADD, ALUC_SUB, ALUC_SRA, ALUC_BEQ…, ALUC_JAL = 11111);
  - M func3 encodings;
  - FSM state enum (IDLE, CALC, DONE).
- Sub-module muldiv_iter (XLEN parameter) holds the operand conversion, shift-add/restoring datapath, fast-path detect, and sign fix-up. The top level keeps the decoder and FSM.

## Test plan
- SUB: aluop 000, func3 000, func7 10 → next cycle aluc_valid_o=1, aluc_o=01000, ready_o stays 1. Then aluop 010, func3 010 → illegal_o=1, aluc_o=00000.
- MUL: rs1=0xFFFFFFFD, rs2=7 → md_result_o=0xFFFFFFEB, with md_valid_o exactly 33 cycles after accept and ready_o low for 32 cycles. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIVU 100/7 → 14; REMU → 2. DIV −100/7 → 0xFFFFFFF2 (−14); REM → 0xFFFFFFFE (−2).
- DIV 100/0 → 0xFFFFFFFF and REM → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. Each is valid one cycle after accept.
- flush_i at CALC cycle 10, and separately rst_i mid-CALC → IDLE next cycle, no md_valid_o, ready_o=1. A new ADD is accepted immediately.
- Back-to-back: issue an ADD in the same cycle md_valid_o is high in DONE → ADD is accepted, and aluc_valid_o and aluc_o=00000 appear in the following cycle.
